// File: rtl/l2_cache_pkg.sv
// Shared encodings for the L2 access controller: request ops, FSM states, line geometry.
package l2_cache_pkg;

  localparam int LINE_BYTES = 64;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_WRITE      = 2'b01,
    OP_INVALIDATE = 2'b10,
    OP_RESERVED   = 2'b11
  } l2_op_e;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    UPDATE,
    RESP
  } l2_state_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: heap-ordered node bits (node n has children 2n+1, 2n+2); a 0 bit points left.
// Returns the victim the tree points at and the bits after touching access_way.
module plru_tree #(
  parameter int ways    = 8,
  parameter int wayBits = $clog2(ways)
) (
  input  logic [ways-2:0]    bits,
  input  logic [wayBits-1:0] access_way,
  output logic [wayBits-1:0] victim_way,
  output logic [ways-2:0]    next_bits
);

  logic [wayBits-1:0] vic_node;
  logic [wayBits-1:0] upd_node;

  always_comb begin
    victim_way = '0;
    next_bits  = bits;
    vic_node   = '0;
    upd_node   = '0;
    for (int lvl = 0; lvl < wayBits; lvl++) begin
      victim_way[wayBits-1-lvl] = bits[vic_node];
      vic_node = bits[vic_node] ? (vic_node << 1) + wayBits'(2) : (vic_node << 1) + wayBits'(1);
      // every node on the accessed path is turned to face the other subtree
      next_bits[upd_node] = ~access_way[wayBits-1-lvl];
      upd_node = access_way[wayBits-1-lvl] ? (upd_node << 1) + wayBits'(2)
                                           : (upd_node << 1) + wayBits'(1);
    end
  end

endmodule

// File: rtl/l2_access_controller.sv
// Set-associative L2 lookup sequencer owning valid/dirty/tag/PLRU metadata per set.
// Define L2_STATS_EN to add saturating hit/miss/writeback counters.
module l2_access_controller
  import l2_cache_pkg::*;
#(
  parameter int ways        = 8,
  parameter int indexBits   = 14,
  parameter int tagBits     = 10,
  parameter int offsetBits  = 6,
  parameter int addressBits = 30
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       reqValid,
  output logic                       reqReady,
  input  logic [1:0]                 reqOp,
  input  logic [addressBits-1:0]     reqAddress,
  output logic                       respValid,
  output logic                       respHit,
  output logic [$clog2(ways)-1:0]    respWay,
  output logic                       memReqValid,
  input  logic                       memReqReady,
  output logic                       memReqWrite,
  output logic [addressBits-1:0]     memReqAddress,
  input  logic                       memAckValid
`ifdef L2_STATS_EN
  ,
  output logic [31:0]                hitCount,
  output logic [31:0]                missCount,
  output logic [31:0]                writebackCount
`endif
);

  localparam int numSets = 1 << indexBits;
  localparam int wayBits = $clog2(ways);

  l2_state_e              state_q, state_d;
  logic [indexBits-1:0]   init_idx_q, init_idx_d;
  l2_op_e                 op_q, op_d;
  logic [tagBits-1:0]     req_tag_q, req_tag_d;
  logic [indexBits-1:0]   req_idx_q, req_idx_d;
  logic                   hit_q, hit_d;
  logic [wayBits-1:0]     way_q, way_d;
  logic                   accepted_q, accepted_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_hit_q, resp_hit_d;
  logic [wayBits-1:0]     resp_way_q, resp_way_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic                   mem_req_write_q, mem_req_write_d;
  logic [addressBits-1:0] mem_req_addr_q, mem_req_addr_d;

  logic [ways-1:0]        valid_q [numSets];
  logic [ways-1:0]        dirty_q [numSets];
  logic [tagBits-1:0]     tag_q   [numSets][ways];
  logic [ways-2:0]        plru_q  [numSets];

  logic [ways-1:0]        set_valid, set_dirty, tag_match;
  logic                   lookup_hit, any_free;
  logic [wayBits-1:0]     hit_way, free_way, victim_way, plru_victim, plru_access;
  logic [ways-2:0]        plru_next;
  logic                   init_clear, meta_we, meta_valid, meta_dirty, plru_we;
  logic [wayBits-1:0]     meta_way;
  logic                   unused_offset_bits;

  assign unused_offset_bits = ^reqAddress[offsetBits-1:0];
  assign set_valid   = valid_q[req_idx_q];
  assign set_dirty   = dirty_q[req_idx_q];
  assign plru_access = (state_q == UPDATE) ? way_q : hit_way;
  assign victim_way  = any_free ? free_way : plru_victim;

  always_comb begin
    tag_match = '0;
    hit_way   = '0;
    free_way  = '0;
    for (int w = 0; w < ways; w++) begin
      tag_match[w] = set_valid[w] && (tag_q[req_idx_q][w] == req_tag_q);
    end
    // descending scan so the lowest matching / lowest free way wins
    for (int w = ways - 1; w >= 0; w--) begin
      if (tag_match[w]) hit_way = wayBits'(w);
      if (!set_valid[w]) free_way = wayBits'(w);
    end
    lookup_hit = |tag_match;
    any_free   = ~&set_valid;
  end

  plru_tree #(.ways(ways), .wayBits(wayBits)) u_plru (
    .bits       (plru_q[req_idx_q]),
    .access_way (plru_access),
    .victim_way (plru_victim),
    .next_bits  (plru_next)
  );

  always_comb begin
    state_d         = state_q;
    init_idx_d      = init_idx_q;
    op_d            = op_q;
    req_tag_d       = req_tag_q;
    req_idx_d       = req_idx_q;
    hit_d           = hit_q;
    way_d           = way_q;
    accepted_d      = accepted_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_hit_d      = 1'b0;
    resp_way_d      = '0;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_write_d = mem_req_write_q;
    mem_req_addr_d  = mem_req_addr_q;
    init_clear      = 1'b0;
    meta_we         = 1'b0;
    meta_way        = way_q;
    meta_valid      = 1'b0;
    meta_dirty      = 1'b0;
    plru_we         = 1'b0;

    case (state_q)
      INIT: begin
        init_clear = 1'b1;
        init_idx_d = init_idx_q + indexBits'(1);
        if (&init_idx_q) state_d = IDLE;
      end
      IDLE: begin
        if (reqValid && req_ready_q) begin
          op_d      = (reqOp == OP_RESERVED) ? OP_READ : l2_op_e'(reqOp);
          req_tag_d = reqAddress[addressBits-1 -: tagBits];
          req_idx_d = reqAddress[offsetBits +: indexBits];
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d      = lookup_hit;
        way_d      = lookup_hit ? hit_way : victim_way;
        meta_way   = hit_way;
        accepted_d = 1'b0;
        if (lookup_hit) begin
          case (op_q)
            OP_WRITE: begin
              meta_we    = 1'b1;
              meta_valid = 1'b1;
              meta_dirty = 1'b1;
              plru_we    = 1'b1;
              state_d    = RESP;
            end
            OP_INVALIDATE: begin
              if (set_dirty[hit_way]) begin
                state_d         = WRITEBACK;
                mem_req_valid_d = 1'b1;
                mem_req_write_d = 1'b1;
                mem_req_addr_d  = {tag_q[req_idx_q][hit_way], req_idx_q, {offsetBits{1'b0}}};
              end else begin
                meta_we = 1'b1;
                state_d = RESP;
              end
            end
            default: begin
              plru_we = 1'b1;
              state_d = RESP;
            end
          endcase
        end else if (op_q == OP_INVALIDATE) begin
          way_d   = '0;
          state_d = RESP;
        end else if (set_valid[victim_way] && set_dirty[victim_way]) begin
          state_d         = WRITEBACK;
          mem_req_valid_d = 1'b1;
          mem_req_write_d = 1'b1;
          mem_req_addr_d  = {tag_q[req_idx_q][victim_way], req_idx_q, {offsetBits{1'b0}}};
        end else begin
          state_d         = FILL;
          mem_req_valid_d = 1'b1;
          mem_req_write_d = 1'b0;
          mem_req_addr_d  = {req_tag_q, req_idx_q, {offsetBits{1'b0}}};
        end
      end
      WRITEBACK, FILL: begin
        // an ack only counts once the request was accepted on an earlier edge
        if (!accepted_q) begin
          if (memReqReady) begin
            mem_req_valid_d = 1'b0;
            accepted_d      = 1'b1;
          end
        end else if (memAckValid) begin
          accepted_d = 1'b0;
          if (state_q == FILL) begin
            state_d = UPDATE;
          end else if (op_q == OP_INVALIDATE) begin
            meta_we = 1'b1;
            state_d = RESP;
          end else begin
            state_d         = FILL;
            mem_req_valid_d = 1'b1;
            mem_req_write_d = 1'b0;
            mem_req_addr_d  = {req_tag_q, req_idx_q, {offsetBits{1'b0}}};
          end
        end
      end
      UPDATE: begin
        meta_we    = 1'b1;
        meta_valid = 1'b1;
        meta_dirty = (op_q == OP_WRITE);
        plru_we    = 1'b1;
        state_d    = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = INIT;
    endcase

    req_ready_d = (state_d == IDLE);
    if (state_d == RESP) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = hit_d;
      resp_way_d   = way_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= INIT;
      init_idx_q      <= '0;
      op_q            <= OP_READ;
      req_tag_q       <= '0;
      req_idx_q       <= '0;
      hit_q           <= 1'b0;
      way_q           <= '0;
      accepted_q      <= 1'b0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_way_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      init_idx_q      <= init_idx_d;
      op_q            <= op_d;
      req_tag_q       <= req_tag_d;
      req_idx_q       <= req_idx_d;
      hit_q           <= hit_d;
      way_q           <= way_d;
      accepted_q      <= accepted_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_hit_q      <= resp_hit_d;
      resp_way_q      <= resp_way_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_write_q <= mem_req_write_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  // metadata arrays have no reset; the INIT sweep clears them one set per cycle
  always_ff @(posedge clock) begin
    if (init_clear) begin
      valid_q[init_idx_q] <= '0;
      dirty_q[init_idx_q] <= '0;
      plru_q[init_idx_q]  <= '0;
    end else begin
      if (meta_we) begin
        valid_q[req_idx_q][meta_way] <= meta_valid;
        dirty_q[req_idx_q][meta_way] <= meta_dirty;
        tag_q[req_idx_q][meta_way]   <= req_tag_q;
      end
      if (plru_we) plru_q[req_idx_q] <= plru_next;
    end
  end

  assign reqReady      = req_ready_q;
  assign respValid     = resp_valid_q;
  assign respHit       = resp_hit_q;
  assign respWay       = resp_way_q;
  assign memReqValid   = mem_req_valid_q;
  assign memReqWrite   = mem_req_write_q;
  assign memReqAddress = mem_req_addr_q;

`ifdef L2_STATS_EN
  logic [31:0] hit_count_q, miss_count_q, wb_count_q;
  logic        hit_evt, miss_evt, wb_evt;

  assign hit_evt  = (state_q == LOOKUP) && (op_q != OP_INVALIDATE) && lookup_hit;
  assign miss_evt = (state_q == LOOKUP) && (op_q != OP_INVALIDATE) && !lookup_hit;
  assign wb_evt   = (state_q == WRITEBACK) && accepted_q && memAckValid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if (hit_evt && (hit_count_q != '1)) hit_count_q <= hit_count_q + 32'd1;
      if (miss_evt && (miss_count_q != '1)) miss_count_q <= miss_count_q + 32'd1;
      if (wb_evt && (wb_count_q != '1)) wb_count_q <= wb_count_q + 32'd1;
    end
  end

  assign hitCount       = hit_count_q;
  assign missCount      = miss_count_q;
  assign writebackCount = wb_count_q;
`endif

endmodule
